// File: rtl/seq_mult_pkg.sv
// Shared definitions for the seq_mult16 iterative multiplier: default operand
// width, iteration-counter width, FSM state encoding and the magnitude/negate
// helpers used on the operand and product paths.
package seq_mult_pkg;

    localparam int MULT_W = 16;
    localparam int CNT_W  = $clog2(MULT_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    // Magnitude of a two's-complement operand. The most negative value maps to
    // itself, which is the correct magnitude when read as unsigned.
    function automatic logic [MULT_W-1:0] abs_w(input logic [MULT_W-1:0] x);
        return x[MULT_W-1] ? ('0 - x) : x;
    endfunction

    // Two's-complement negation of a double-width product.
    function automatic logic [2*MULT_W-1:0] negate_2w(input logic [2*MULT_W-1:0] x);
        return '0 - x;
    endfunction

endpackage

// File: rtl/mult_add_stage.sv
// Partial-product adder for seq_mult16: WIDTH + WIDTH -> WIDTH+1 with the
// carry kept. Purely combinational so it can be swapped for the CLA stage.
module mult_add_stage #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/seq_mult16.sv
// seq_mult16: iterative shift-and-add multiplier, one partial-product add per
// cycle, signed/unsigned operands, double-width product plus overflow flag,
// ready/valid on both sides.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN -- leave RUN as soon as the
// unconsumed multiplier bits are all zero, shifting the accumulator by the
// skipped count so the product is unchanged.
module seq_mult16
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               ovflow,
    output logic               busy
);

    state_e               state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic [WIDTH-1:0]     acc_hi_q,  acc_hi_d;
    logic                 neg_q,     neg_d;
    logic                 sgn_q,     sgn_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ovflow_q,  ovflow_d;

    // Datapath for one RUN iteration: conditional add, then a 1-bit right
    // shift of {carry, acc_hi, mplier}. Product low bits fill mplier from the top.
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     acc_shift;
    logic [WIDTH-1:0]     mplier_shift;
    logic [2*WIDTH-1:0]   run_next;
    logic                 run_exit;

    assign addend = mplier_q[0] ? mcand_q : '0;

    mult_add_stage #(
        .WIDTH (WIDTH)
    ) u_add (
        .a_i   (acc_hi_q),
        .b_i   (addend),
        .sum_o (sum)
    );

    assign acc_shift    = sum[WIDTH:1];
    assign mplier_shift = {sum[0], mplier_q[WIDTH-1:1]};

`ifdef SEQ_MULT_EARLY_TERM_EN
    // After iteration cnt_q, the low WIDTH-1-cnt_q bits of mplier_shift are the
    // multiplier bits not yet consumed. If they are all zero, every remaining
    // iteration is a pure shift, so apply all of them at once.
    logic [WIDTH-1:0]     live_mask;
    logic [CNT_W-1:0]     skip;

    assign live_mask = {WIDTH{1'b1}} >> cnt_q >> 1;
    assign skip      = CNT_W'(WIDTH-1) - cnt_q;
    assign run_exit  = ~|(mplier_shift & live_mask);
    assign run_next  = {acc_shift, mplier_shift} >> skip;
`else
    assign run_exit  = (cnt_q == CNT_W'(WIDTH-1));
    assign run_next  = {acc_shift, mplier_shift};
`endif

    // Sign fix-up and overflow evaluation applied in FIX.
    logic [2*WIDTH-1:0]   fix_product;
    logic                 fix_ovflow;

    assign fix_product = neg_q ? negate_2w({acc_hi_q, mplier_q}) : {acc_hi_q, mplier_q};
    assign fix_ovflow  = sgn_q ? (fix_product[2*WIDTH-1:WIDTH] != {WIDTH{fix_product[WIDTH-1]}})
                               : (|fix_product[2*WIDTH-1:WIDTH]);

    // Next-state and datapath update for the IDLE -> RUN -> FIX -> DONE sequence.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_hi_d  = acc_hi_q;
        neg_d     = neg_q;
        sgn_d     = sgn_q;
        product_d = product_q;
        ovflow_d  = ovflow_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = sign ? abs_w(a) : a;
                    mplier_d = sign ? abs_w(b) : b;
                    neg_d    = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sgn_d    = sign;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                {acc_hi_d, mplier_d} = run_next;
                cnt_d                = cnt_q + 1'b1;
                if (run_exit) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                product_d = fix_product;
                ovflow_d  = fix_ovflow;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_hi_q  <= '0;
            neg_q     <= 1'b0;
            sgn_q     <= 1'b0;
            product_q <= '0;
            ovflow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_hi_q  <= acc_hi_d;
            neg_q     <= neg_d;
            sgn_q     <= sgn_d;
            product_q <= product_d;
            ovflow_q  <= ovflow_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign product   = product_q;
    assign ovflow    = ovflow_q;

endmodule
